// File: rtl/div_seq_pkg.sv
// Shared types and constants for the div_seq operand sequencer.
// Optional statistics outputs are enabled with the DIV_SEQ_STATS_EN macro.
package div_seq_pkg;

  localparam int DATA_W            = 16;
  localparam int CNT_W             = 8;
  localparam int DEF_FIFO_DEPTH    = 4;
  localparam int DEF_SETTLE_CYCLES = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/div_seq_fifo.sv
// Operand buffer for div_seq: power-of-two depth, registered occupancy,
// combinational head read so the sequencer can load the head on pop.
module div_seq_fifo
  import div_seq_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides validity,
  // which keeps the array mappable to plain RAM/flops without reset fan-out.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);

endmodule

// File: rtl/div_seq.sv
// Sequences buffered operands through an external fixed-latency divider.
// Define DIV_SEQ_STATS_EN to add the stat_done / stat_drop outputs.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] dv_x,
  output logic              dv_start,
  input  logic [DATA_W-1:0] dv_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_x
`ifdef DIV_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_done,
  output logic              stat_drop
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_start;
  logic              w_capture;
  logic              w_out_valid;
  logic [DATA_W-1:0] r_dv_x;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_out_x;

  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;

  div_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        w_start      = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == CNT_ONE) begin
          w_capture    = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // The divider sees dv_x for the whole START..WAIT window; it only changes on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv_x     <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_x    <= '0;
    end else begin
      if (w_pop) r_dv_x <= w_fifo_dout;
      if (w_start) begin
        r_cnt <= SETTLE_CNT;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      if (w_capture) begin
        r_out_data <= dv_y;
        r_out_x    <= r_dv_x;
      end
    end
  end

  assign dv_x      = r_dv_x;
  assign dv_start  = w_start;
  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign out_x     = r_out_x;

`ifdef DIV_SEQ_STATS_EN
  logic [15:0] r_stat_done;

  always_ff @(posedge clk) begin
    if (rst)                          r_stat_done <= '0;
    else if (out_valid && out_ready)  r_stat_done <= r_stat_done + 16'd1;
  end

  assign stat_done = r_stat_done;
  assign stat_drop = in_valid && !in_ready;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: transaction-level model plus randomized
// traffic, backpressure, full-buffer and mid-operation reset scenarios.
module tb_div_seq;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 40;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] dv_x;
  logic        dv_start;
  logic [15:0] dv_y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_x;
`ifdef DIV_SEQ_STATS_EN
  logic [15:0] stat_done;
  logic        stat_drop;
  logic [15:0] m_done16;
`endif

  int n_checks;
  int n_fail;
  int n_results;

  // Transaction-level model state
  logic [15:0] m_q[$];
  bit          m_busy;
  int          m_age;
  logic [15:0] m_cur;

  // Environment divider: output depends on operand and cycles since start
  int          dv_k;
  logic [15:0] dv_op;

  div_seq #(
    .FIFO_DEPTH    (DEPTH),
    .SETTLE_CYCLES (SETTLE)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .dv_x      (dv_x),
    .dv_start  (dv_start),
    .dv_y      (dv_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_x     (out_x)
`ifdef DIV_SEQ_STATS_EN
    ,
    .stat_done (stat_done),
    .stat_drop (stat_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] div_model(input logic [15:0] x, input int k);
    int q;
    q = 32'hFFFF / ((x == 16'd0) ? 1 : int'(x));
    return 16'(q + k * 257);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    dv_k  = 0;
    dv_op = '0;
    dv_y  = '0;
  end

  always @(negedge clk) begin
    if (dv_start) begin
      dv_k  = 0;
      dv_op = dv_x;
    end else begin
      dv_k++;
    end
    dv_y = div_model(dv_op, dv_k);
  end

  // Compare process: one evaluation per cycle, then model advances to the next cycle
  always @(negedge clk) begin
    bit exp_ready;
    bit exp_valid;
    if (rst) begin
      m_q.delete();
      m_busy = 1'b0;
      m_age  = 0;
`ifdef DIV_SEQ_STATS_EN
      m_done16 = '0;
`endif
    end else begin
      exp_ready = (m_q.size() < DEPTH);
      exp_valid = m_busy && (m_age >= SETTLE + 2);
      check("in_ready", in_ready, exp_ready);
      check("dv_start", dv_start, m_busy && (m_age == 1));
      check("out_valid", out_valid, exp_valid);
      if (m_busy) check("dv_x", dv_x, m_cur);
      if (exp_valid) begin
        check("out_x", out_x, m_cur);
        check("out_data", out_data, div_model(m_cur, SETTLE));
      end
`ifdef DIV_SEQ_STATS_EN
      check("stat_done", stat_done, m_done16);
      check("stat_drop", stat_drop, in_valid && !exp_ready);
`endif
      if (m_busy) begin
        if (exp_valid && out_ready) begin
          m_busy = 1'b0;
          n_results++;
`ifdef DIV_SEQ_STATS_EN
          m_done16 = m_done16 + 16'd1;
`endif
        end else begin
          m_age++;
        end
      end else if (m_q.size() != 0) begin
        m_cur  = m_q.pop_front();
        m_busy = 1'b1;
        m_age  = 1;
      end
      if (in_valid && exp_ready) m_q.push_back(in_data);
    end
  end

  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] d);
    bit a;
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 500 && !got; c++) begin
      step(a);
      got = a;
    end
    in_valid = 1'b0;
    check("push_accepted", got, 1'b1);
  endtask

  task automatic wait_idle();
    bit a;
    bit idle;
    idle = !m_busy && (m_q.size() == 0);
    for (int c = 0; c < 5000 && !idle; c++) begin
      step(a);
      idle = !m_busy && (m_q.size() == 0);
    end
    check("idle_reached", idle, 1'b1);
    step(a);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_dv_start", dv_start, 1'b0);
    check("rst_dv_x", dv_x, 16'h0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_x", out_x, 16'h0000);
  endtask

  task automatic run_random(input int n_ops, input int ready_pct);
    int  n_acc;
    int  base;
    bit  a;
    base  = n_results;
    n_acc = 0;
    for (int c = 0; c < 20000 && n_acc < n_ops; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      step(a);
      if (a) n_acc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    check("random_results", n_results - base, n_ops);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit a;
    int n;
    int base;
    n_checks  = 0;
    n_fail    = 0;
    n_results = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals();

    // Single operation: latency from pop to out_valid and captured values
    push_one(16'h1234);
    n = 0;
    while (!out_valid && n < 200) begin
      step(a);
      n++;
    end
    check("single_latency", n, SETTLE + 2);
    check("single_out_x", out_x, 16'h1234);
    check("single_out_data", out_data, 16'h2836);
    wait_idle();

    // Backpressure in HOLD while the buffer fills; fifth operand waits for a pop
    base      = n_results;
    out_ready = 1'b0;
    push_one(16'hA5A5);
    n = 0;
    while (!out_valid && n < 200) begin
      step(a);
      n++;
    end
    check("bp_reached_hold", out_valid, 1'b1);
    for (int i = 1; i <= 4; i++) push_one(16'(i));
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd5;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      step(a);
      if (a) n++;
    end
    check("full_no_accept", n, 0);
    check("bp_still_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    n = 0;
    a = 1'b0;
    while (!a && n < 200) begin
      step(a);
      n++;
    end
    check("fifth_accepted", a, 1'b1);
    in_valid = 1'b0;
    wait_idle();
    check("fill_results", n_results - base, 6);

    // Pointer wrap with continuous draining, then random traffic with stalls
    run_random(12, 100);
    run_random(30, 60);

    // Reset while waiting on the divider with three operands buffered
    base = n_results;
    out_ready = 1'b1;
    push_one(16'h1111);
    push_one(16'h2222);
    push_one(16'h3333);
    push_one(16'h4444);
    n = 0;
    while (!(m_busy && m_age >= 5) && n < 100) begin
      step(a);
      n++;
    end
    check("abort_in_wait", m_busy && (m_q.size() == 3), 1'b1);
    rst = 1'b1;
    step(a);
    rst = 1'b0;
    check_reset_vals();
    repeat (150) step(a);
    check("abort_no_results", n_results - base, 0);

    run_random(8, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
